// File: rtl/snd_pkg.sv
// Shared definitions for the sound scheduler slice.
// Contents:
//   SND_* codes - code_sound encodings. Numeric order equals priority order.
//   state_t     - scheduler states.
//   snd_winner  - fixed-priority pick (go > ping > pong) from three request bits.
package snd_pkg;

  localparam logic [1:0] SND_STOP = 2'b00;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_PING = 2'b10;
  localparam logic [1:0] SND_GO   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Returns the winning sound code, or SND_STOP when nothing is requested.
  function automatic logic [1:0] snd_winner(input logic go, input logic ping, input logic pong);
    logic [1:0] w;
    w = SND_STOP;
    if (go)        w = SND_GO;
    else if (ping) w = SND_PING;
    else if (pong) w = SND_PONG;
    return w;
  endfunction

endpackage

// File: rtl/snd_timer.sv
// Loadable down-counter used to time sounds and gaps.
// Ports:
//   clk    - system clock
//   clr    - synchronous active-high reset (count -> 0)
//   load   - load 'value' into the count this edge
//   value  - load value (duration minus one)
//   zero_c - combinational flag, count is zero
// The count decrements every cycle while non-zero and parks at zero.
module snd_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr)          cnt_q <= '0;
    else if (load)    cnt_q <= value;
    else if (!zero_c) cnt_q <= cnt_q - CNT_W'(1);
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sound_scheduler.sv
// Arbitrates go/ping/pong bounce events and sequences each sound for its
// programmed duration followed by a silent gap, so sounds never overlap
// or truncate.
// Ports:
//   clk        - system clock
//   clr        - synchronous active-high reset
//   evt_go     - start event (one-cycle pulse)
//   evt_ping   - y-border bounce event
//   evt_pong   - x-border bounce event
//   silence    - forces mute while timing continues
//   code_sound - 00 stop, 01 pong, 10 ping, 11 go (registered)
//   mute       - tone generator silent (registered)
//   busy       - playing, in a gap, or a request is pending (registered)
// Build option: define SOUND_PREEMPT_EN to let a strictly higher-priority
// request cut the current sound or gap and restart PLAY immediately.
module sound_scheduler
  import snd_pkg::*;
#(
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DUR_GO      = 2400000,
  parameter int unsigned DUR_PING    = 1200000,
  parameter int unsigned DUR_PONG    = 1200000,
  parameter int unsigned GAP         = 120000,
  parameter bit          GO_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       evt_go,
  input  logic       evt_ping,
  input  logic       evt_pong,
  input  logic       silence,
  output logic [1:0] code_sound,
  output logic       mute,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LD_GO   = CNT_W'(DUR_GO - 1);
  localparam logic [CNT_W-1:0] LD_PING = CNT_W'(DUR_PING - 1);
  localparam logic [CNT_W-1:0] LD_PONG = CNT_W'(DUR_PONG - 1);
  localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(GAP - 1);
  localparam bit               HAS_GAP = (GAP != 0);

  state_t           state_q, state_d;
  logic [1:0]       cur_q, cur_d, win;
  logic             pend_go_q, pend_ping_q, pend_pong_q;
  logic             pend_go_d, pend_ping_d, pend_pong_d;
  logic             req_go, req_ping, req_pong, any_req;
  logic             grant, next_step;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic [1:0]       code_d;
  logic             mute_d, busy_d;

  assign req_go   = pend_go_q   | evt_go;
  assign req_ping = pend_ping_q | evt_ping;
  assign req_pong = pend_pong_q | evt_pong;
  assign any_req  = req_go | req_ping | req_pong;
  assign win      = snd_winner(req_go, req_ping, req_pong);

  snd_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .clr    (clr),
    .load   (tmr_load),
    .value  (tmr_val),
    .zero_c (tmr_zero)
  );

  // State register, request flags and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cur_q       <= SND_STOP;
      pend_go_q   <= GO_ON_RESET;
      pend_ping_q <= 1'b0;
      pend_pong_q <= 1'b0;
      code_sound  <= SND_STOP;
      mute        <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_go_q   <= pend_go_d;
      pend_ping_q <= pend_ping_d;
      pend_pong_q <= pend_pong_d;
      code_sound  <= code_d;
      mute        <= mute_d;
      busy        <= busy_d;
    end
  end

  // Next state, grant decision, timer reloads and request bookkeeping.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    grant     = 1'b0;
    next_step = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      ST_IDLE: grant = any_req;
      ST_PLAY: begin
        if (tmr_zero) begin
          if (HAS_GAP) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = LD_GAP;
          end else begin
            next_step = 1'b1;
          end
        end
      end
      ST_GAP:  next_step = tmr_zero;
      default: state_d = ST_IDLE;
    endcase

    if (next_step) begin
      if (any_req) grant = 1'b1;
      else         state_d = ST_IDLE;
    end

`ifdef SOUND_PREEMPT_EN
    // Codes are ordered by priority, so a larger code outranks the current one.
    if (state_q != ST_IDLE && any_req && win > cur_q) grant = 1'b1;
`endif

    if (grant) begin
      state_d  = ST_PLAY;
      cur_d    = win;
      tmr_load = 1'b1;
      case (win)
        SND_GO:   tmr_val = LD_GO;
        SND_PING: tmr_val = LD_PING;
        default:  tmr_val = LD_PONG;
      endcase
    end

    // A same-type event coinciding with its own grant is absorbed.
    pend_go_d   = req_go   & ~(grant & (win == SND_GO));
    pend_ping_d = req_ping & ~(grant & (win == SND_PING));
    pend_pong_d = req_pong & ~(grant & (win == SND_PONG));
  end

  // Output values to be registered alongside the next state.
  always_comb begin
    code_d = SND_STOP;
    mute_d = 1'b1;
    if (state_d == ST_PLAY) begin
      code_d = cur_d;
      mute_d = silence;
    end
    busy_d = (state_d != ST_IDLE) | pend_go_d | pend_ping_d | pend_pong_d;
  end

endmodule
